cpu_ctrl: RTL

Multi-cycle control unit for the 8-bit RISC-like CPU. Fetches 16-bit instructions over a req/ack instruction-memory port, decodes them, drives the register file, the 8-bit ALU and a req/ack data-memory port, and owns the program counter and zero-flag register. Every instruction passes through a fixed FSM, one step per state. This block sequences the ALU; the ALU itself stays purely combinational.

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/cpu_ctrl_decode.sv | 83 ++++++++
 rtl/cpu_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the CPU control unit: instruction field positions,
// opcode values, and the small encodings passed between the decoder and the
// sequencer (operand selects and the post-EXEC next-state class).
package cpu_ctrl_pkg;

  // Instruction word fields
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 10;
  localparam int RB_HI  = 9;
  localparam int RB_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes (14 and 15 are treated as HALT)
  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_CMP   = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_SUBI  = 4'd6;
  localparam logic [3:0] OP_CMPI  = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_JMPR  = 4'd11;
  localparam logic [3:0] OP_JNZ   = 4'd12;
  localparam logic [3:0] OP_LI    = 4'd13;

  // ALU operand 0 source
  localparam logic IN0_RB  = 1'b0;
  localparam logic IN0_IMM = 1'b1;

  // ALU operand 1 source
  localparam logic [1:0] IN1_RA   = 2'd0;
  localparam logic [1:0] IN1_RB   = 2'd1;
  localparam logic [1:0] IN1_ZERO = 2'd2;

  // Where the instruction goes after EXEC (HALT is taken straight from DECODE)
  localparam logic [1:0] NXT_FETCH = 2'd0;
  localparam logic [1:0] NXT_WB    = 2'd1;
  localparam logic [1:0] NXT_MEM   = 2'd2;
  localparam logic [1:0] NXT_HALT  = 2'd3;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode decoder for cpu_ctrl.
// Ports:
//   op        in  4  opcode field of the latched instruction
//   in0_sel   out 1  ALU operand 0 source (R[rb] or imm)
//   in1_sel   out 2  ALU operand 1 source (R[ra], R[rb] or zero)
//   nxt       out 2  next-state class after EXEC (or HALT)
//   zf_en     out 1  zero flag is updated in EXEC
//   is_store  out 1  memory access is a store
//   jump      out 1  instruction writes PC in EXEC
//   jump_cond out 1  jump only when the zero flag is clear (JNZ)
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output logic       in0_sel,
  output logic [1:0] in1_sel,
  output logic [1:0] nxt,
  output logic       zf_en,
  output logic       is_store,
  output logic       jump,
  output logic       jump_cond
);

  always_comb begin
    in0_sel   = IN0_IMM;
    in1_sel   = IN1_ZERO;
    nxt       = NXT_FETCH;
    zf_en     = 1'b0;
    is_store  = 1'b0;
    jump      = 1'b0;
    jump_cond = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: begin
        in0_sel = IN0_RB;
        in1_sel = IN1_RA;
        nxt     = NXT_WB;
        zf_en   = 1'b1;
      end
      OP_CMP: begin
        in0_sel = IN0_RB;
        in1_sel = IN1_RA;
        zf_en   = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        in1_sel = IN1_RA;
        nxt     = NXT_WB;
        zf_en   = 1'b1;
      end
      OP_CMPI: begin
        in1_sel = IN1_RA;
        zf_en   = 1'b1;
      end
      OP_LOAD: begin
        in1_sel = IN1_RB;
        nxt     = NXT_MEM;
      end
      OP_STORE: begin
        in1_sel  = IN1_RB;
        nxt      = NXT_MEM;
        is_store = 1'b1;
      end
      OP_JMP: begin
        jump = 1'b1;
      end
      OP_JMPR: begin
        in1_sel = IN1_RB;
        jump    = 1'b1;
      end
      OP_JNZ: begin
        jump      = 1'b1;
        jump_cond = 1'b1;
      end
      OP_LI: begin
        nxt = NXT_WB;
      end
      default: begin
        nxt = NXT_HALT;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl
// Multi-cycle control unit of the 8-bit CPU. Sequences every instruction
// through FETCH -> DECODE -> EXEC -> [MEM] -> [WB], owns PC and the zero flag,
// and drives the external register file, ALU and both memory ports.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   imem_req/addr/ack/rdata          instruction fetch port (req/ack)
//   dmem_req/we/addr/wdata/ack/rdata data memory port (req/ack)
//   rf_raddr_a/b, rf_rdata_a/b       register file read ports (comb. read)
//   rf_we/waddr/wdata                register file write port
//   alu_op/in0/in1, alu_out/alu_zf   external combinational ALU
//   pc                               current program counter (debug)
//   halted                           high while in HALT
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic [1:0]  rf_raddr_a,
  output logic [1:0]  rf_raddr_b,
  input  logic [7:0]  rf_rdata_a,
  input  logic [7:0]  rf_rdata_b,
  output logic        rf_we,
  output logic [1:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_in0,
  output logic [7:0]  alu_in1,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q;
  logic [7:0]  res_q;
  logic [15:0] instr_q;
  logic        zf_q;
  // Cleared while reset is held so the first fetch is only requested in the
  // cycle after rst_n is sampled high, and a pending request drops at once.
  logic        run_q;

  logic [3:0] op;
  logic [1:0] ra, rb;
  logic [7:0] imm;
  assign op  = instr_q[OP_HI:OP_LO];
  assign ra  = instr_q[RA_HI:RA_LO];
  assign rb  = instr_q[RB_HI:RB_LO];
  assign imm = instr_q[IMM_HI:IMM_LO];

  logic       in0_sel, zf_en, is_store, jump, jump_cond;
  logic [1:0] in1_sel, nxt;

  ctrl_decode u_decode (
    .op        (op),
    .in0_sel   (in0_sel),
    .in1_sel   (in1_sel),
    .nxt       (nxt),
    .zf_en     (zf_en),
    .is_store  (is_store),
    .jump      (jump),
    .jump_cond (jump_cond)
  );

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign rf_raddr_a = ra;
  assign rf_raddr_b = rb;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      zf_q    <= 1'b1;
      res_q   <= 8'h00;
      instr_q <= 16'h0000;
      run_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          if (run_q && imem_ack) begin
            instr_q <= imem_rdata;
            pc_q    <= pc_q + 8'd1;
          end
        end
        S_EXEC: begin
          res_q <= alu_out;
          if (zf_en) zf_q <= alu_zf;
          // JNZ reads the flag as left by earlier instructions
          if (jump && (!jump_cond || !zf_q)) pc_q <= alu_out;
        end
        S_MEM: begin
          if (dmem_ack && !is_store) res_q <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 8'h00;
    dmem_wdata = 8'h00;
    rf_we      = 1'b0;
    rf_waddr   = 2'd0;
    rf_wdata   = 8'h00;
    alu_op     = 4'd0;
    alu_in0    = 8'h00;
    alu_in1    = 8'h00;
    case (state_q)
      S_FETCH: begin
        imem_req = run_q;
        if (run_q && imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (nxt == NXT_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_op  = op;
        alu_in0 = (in0_sel == IN0_IMM) ? imm : rf_rdata_b;
        case (in1_sel)
          IN1_RA:  alu_in1 = rf_rdata_a;
          IN1_RB:  alu_in1 = rf_rdata_b;
          default: alu_in1 = 8'h00;
        endcase
        case (nxt)
          NXT_WB:  state_d = S_WB;
          NXT_MEM: state_d = S_MEM;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        dmem_addr  = res_q;
        dmem_wdata = is_store ? rf_rdata_a : 8'h00;
        if (dmem_ack) state_d = is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = ra;
        rf_wdata = res_q;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule
